// File: rtl/perceptron_trainer.sv
// Perceptron branch-predictor trainer: dot-product prediction with an
// in-flight FIFO that retrains weights when outcomes resolve.
module perceptron_trainer #(
   parameter int THETA = 44,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         lookup_valid,
   output logic         lookup_ready,
   input  logic [47:0]  perceptron_weights,
   input  logic [159:0] index,
   input  logic [15:0]  history,
   output logic         pred_valid,
   output logic         pred_taken,
   output logic [7:0]   pred_sum,
   input  logic         resolve_valid,
   input  logic         resolve_taken,
   input  logic         flush,
   output logic         en_1,
   output logic [47:0]  perceptron_weights_update,
   output logic [159:0] index_update,
   output logic         overflow,
   output logic         underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [47:0]  w_mem    [DEPTH];
   logic [159:0] idx_mem  [DEPTH];
   logic [15:0]  hist_mem [DEPTH];
   logic [7:0]   sum_mem  [DEPTH];
   logic         pred_mem [DEPTH];

   logic [AW:0]   wr_ptr, rd_ptr;
   logic [AW-1:0] wr_slot, rd_slot;
   logic          full, empty, accept, push, pop, train;
   logic [7:0]    sum, wext, e_sum, abs_sum;
   logic [47:0]   e_w, w_new;
   logic [15:0]   e_hist;
   logic [2:0]    wi;

   assign wr_slot = wr_ptr[AW-1:0];
   assign rd_slot = rd_ptr[AW-1:0];
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_slot == rd_slot);
   assign empty   = (wr_ptr == rd_ptr);
   assign lookup_ready = !full;

   // A lookup accepted during flush still yields a prediction but is not stored.
   assign accept = lookup_valid && !full;
   assign push   = accept && !flush;
   assign pop    = resolve_valid && !empty;

   always_comb begin
      sum  = '0;
      wext = '0;
      for (int i = 0; i < 16; i++) begin
         wext = {{5{perceptron_weights[3*i+2]}}, perceptron_weights[3*i +: 3]};
         sum  = history[i] ? sum + wext : sum - wext;
      end
   end

   assign e_w     = w_mem[rd_slot];
   assign e_hist  = hist_mem[rd_slot];
   assign e_sum   = sum_mem[rd_slot];
   assign abs_sum = e_sum[7] ? 8'd0 - e_sum : e_sum;
   assign train   = pop &&
                    ((pred_mem[rd_slot] != resolve_taken) ||
                     (abs_sum <= 8'(THETA)));

   always_comb begin
      w_new = '0;
      wi    = '0;
      for (int i = 0; i < 16; i++) begin
         wi = e_w[3*i +: 3];
         if (e_hist[i] == resolve_taken)
            w_new[3*i +: 3] = (wi == 3'b011) ? wi : wi + 3'd1;
         else
            w_new[3*i +: 3] = (wi == 3'b100) ? wi : wi - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         w_mem[wr_slot]    <= perceptron_weights;
         idx_mem[wr_slot]  <= index;
         hist_mem[wr_slot] <= history;
         sum_mem[wr_slot]  <= sum;
         pred_mem[wr_slot] <= !sum[7];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr                    <= '0;
         rd_ptr                    <= '0;
         pred_valid                <= 1'b0;
         pred_taken                <= 1'b0;
         pred_sum                  <= '0;
         en_1                      <= 1'b0;
         perceptron_weights_update <= '0;
         index_update              <= '0;
         overflow                  <= 1'b0;
         underflow                 <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (flush)
            rd_ptr <= wr_ptr;
         pred_valid <= accept;
         if (accept) begin
            pred_taken <= !sum[7];
            pred_sum   <= sum;
         end
         en_1 <= train;
         if (train) begin
            perceptron_weights_update <= w_new;
            index_update              <= idx_mem[rd_slot];
         end
         if (lookup_valid && full)
            overflow <= 1'b1;
         if (resolve_valid && empty)
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: prediction, training,
// saturation, FIFO full/empty, flush and reset behaviour.
module tb_perceptron_trainer;

   logic         clk = 1'b0;
   logic         rst;
   logic         lookup_valid;
   logic         lookup_ready;
   logic [47:0]  perceptron_weights;
   logic [159:0] index;
   logic [15:0]  history;
   logic         pred_valid, pred_taken;
   logic [7:0]   pred_sum;
   logic         resolve_valid, resolve_taken, flush;
   logic         en_1;
   logic [47:0]  perceptron_weights_update;
   logic [159:0] index_update;
   logic         overflow, underflow;

   int n_cmp = 0;
   int n_err = 0;
   logic [159:0] idx_tab [5];

   always #5 clk = ~clk;

   perceptron_trainer #(.THETA(44), .DEPTH(4)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .lookup_valid              (lookup_valid),
      .lookup_ready              (lookup_ready),
      .perceptron_weights        (perceptron_weights),
      .index                     (index),
      .history                   (history),
      .pred_valid                (pred_valid),
      .pred_taken                (pred_taken),
      .pred_sum                  (pred_sum),
      .resolve_valid             (resolve_valid),
      .resolve_taken             (resolve_taken),
      .flush                     (flush),
      .en_1                      (en_1),
      .perceptron_weights_update (perceptron_weights_update),
      .index_update              (index_update),
      .overflow                  (overflow),
      .underflow                 (underflow)
   );

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      lookup_valid  = 1'b0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
      flush         = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 5; k++)
         idx_tab[k] = {16{10'(k * 37 + 5)}};
      rst = 1'b1;
      idle();
      perceptron_weights = '0;
      index = '0;
      history = '0;
      step();
      step();
      chk("rst_pred_valid", pred_valid, 0);
      chk("rst_en_1", en_1, 0);
      chk("rst_wu", perceptron_weights_update, 0);
      chk("rst_iu", index_update, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      rst = 1'b0;
      step();
      chk("ready_after_rst", lookup_ready, 1);

      // all +1, all taken: sum +16, trains to +2
      lookup_valid = 1'b1;
      perceptron_weights = {16{3'b001}};
      history = 16'hFFFF;
      index = 160'h1234_5678;
      step();
      idle();
      chk("p1_valid", pred_valid, 1);
      chk("p1_sum", pred_sum, 8'd16);
      chk("p1_taken", pred_taken, 1);
      step();
      chk("p1_valid_drop", pred_valid, 0);
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      step();
      idle();
      chk("t1_en", en_1, 1);
      chk("t1_w", perceptron_weights_update, {16{3'b010}});
      chk("t1_idx", index_update, 160'h1234_5678);
      step();
      chk("t1_en_drop", en_1, 0);
      chk("t1_w_hold", perceptron_weights_update, {16{3'b010}});

      // all +3: sum 48 > THETA, correct -> no train
      lookup_valid = 1'b1;
      perceptron_weights = {16{3'b011}};
      index = 160'hBEEF;
      step();
      idle();
      chk("p2_sum", pred_sum, 8'd48);
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      step();
      idle();
      chk("t2_no_train", en_1, 0);
      chk("t2_idx_hold", index_update, 160'h1234_5678);
      lookup_valid = 1'b1;
      index = 160'hCAFE;
      step();
      idle();
      resolve_valid = 1'b1;
      resolve_taken = 1'b0;
      step();
      idle();
      chk("t3_en", en_1, 1);
      chk("t3_w", perceptron_weights_update, {16{3'b010}});
      chk("t3_idx", index_update, 160'hCAFE);

      // saturation at -4: sum 0 trains, low half agrees
      lookup_valid = 1'b1;
      perceptron_weights = {16{3'b100}};
      history = 16'h00FF;
      step();
      idle();
      chk("p4_sum", pred_sum, 8'd0);
      chk("p4_taken", pred_taken, 1);
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      step();
      idle();
      chk("t4_en", en_1, 1);
      chk("t4_w", perceptron_weights_update, {{8{3'b100}}, {8{3'b101}}});

      // saturation at +3
      lookup_valid = 1'b1;
      perceptron_weights = {16{3'b011}};
      step();
      idle();
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      step();
      idle();
      chk("t5_w", perceptron_weights_update, {{8{3'b010}}, {8{3'b011}}});

      // fill FIFO with sum -16 not-taken entries
      perceptron_weights = {16{3'b001}};
      history = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         lookup_valid = 1'b1;
         index = idx_tab[k];
         step();
         chk("fill_valid", pred_valid, 1);
         chk("fill_sum", pred_sum, 8'hF0);
         chk("fill_taken", pred_taken, 0);
      end
      chk("full_ready", lookup_ready, 0);
      chk("pre_ovf", overflow, 0);
      index = idx_tab[4];
      step();
      idle();
      chk("ovf_valid", pred_valid, 0);
      chk("ovf_flag", overflow, 1);
      for (int k = 0; k < 4; k++) begin
         resolve_valid = 1'b1;
         resolve_taken = 1'b1;
         step();
         chk("drain_en", en_1, 1);
         chk("drain_idx", index_update, idx_tab[k]);
         chk("drain_w", perceptron_weights_update, {16{3'b000}});
      end
      idle();
      step();
      chk("drain_ready", lookup_ready, 1);
      chk("ovf_sticky", overflow, 1);

      // flush with 3 pending, plus a lookup in the flush cycle
      for (int k = 0; k < 3; k++) begin
         lookup_valid = 1'b1;
         index = idx_tab[k];
         step();
      end
      flush = 1'b1;
      index = idx_tab[4];
      step();
      idle();
      chk("flush_pred_valid", pred_valid, 1);
      chk("pre_unf", underflow, 0);
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      step();
      idle();
      chk("flush_en", en_1, 0);
      chk("flush_unf", underflow, 1);

      // reset with 2 pending and a resolve in the same cycle
      for (int k = 0; k < 2; k++) begin
         lookup_valid = 1'b1;
         index = idx_tab[k];
         step();
      end
      idle();
      rst = 1'b1;
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      step();
      chk("rst2_en", en_1, 0);
      chk("rst2_w", perceptron_weights_update, 0);
      chk("rst2_idx", index_update, 0);
      chk("rst2_sum", pred_sum, 0);
      chk("rst2_ovf", overflow, 0);
      chk("rst2_unf", underflow, 0);
      rst = 1'b0;
      idle();
      step();
      chk("rst2_ready", lookup_ready, 1);
      resolve_valid = 1'b1;
      step();
      idle();
      chk("rst2_empty_en", en_1, 0);
      chk("rst2_empty_unf", underflow, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
